// File: rtl/keypad_matrix_scanner_pkg.sv
// Shared keypad types: scanner FSM states, per-frame scan result and the
// key-position to display-character map used by the edit logic.
package kp_pkg;

   typedef enum logic [1:0] {IDLE, DEB, HELD, REL} kp_state_t;

   typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_t;

   // Index = {row_idx, col_idx}; value = 5-bit display character code
   // (0-9 digits, A=10, b=11, C=12, d=13, E=14 for '*', F=15 for '#').
   localparam logic [4:0] KEY_MAP [16] = '{
      5'd1,  5'd2, 5'd3,  5'd10,
      5'd4,  5'd5, 5'd6,  5'd11,
      5'd7,  5'd8, 5'd9,  5'd12,
      5'd14, 5'd0, 5'd15, 5'd13
   };

endpackage

// File: rtl/keypad_matrix_scanner_sync2.sv
// 4-bit two-flop synchroniser for asynchronous active-low inputs; resets to
// all-ones so an idle (pulled-up) line never looks pressed.
module sync2 (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] d,
   output logic [3:0] q
);

   logic [3:0] meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 4'hF;
         q    <= 4'hF;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x4 keypad scanner: one active-low column per scan tick, per-frame hit
// accumulation, frame-level debounce FSM with optional auto-repeat.
module keypad_matrix_scanner #(
   parameter int DEBOUNCE_FRAMES = 3,
   parameter int REPEAT_FRAMES   = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick_scan,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       key_held,
   output logic       key_multi
);
   import kp_pkg::*;

   localparam logic [3:0] DEB_N = 4'(DEBOUNCE_FRAMES);
   localparam logic [7:0] REP_N = 8'(REPEAT_FRAMES);

   logic [3:0] row_s;
   logic [1:0] col_idx;
   logic [1:0] hit_q;
   logic [3:0] first_q;
   logic       frm_done;
   logic [1:0] frm_hits;
   logic [3:0] frm_code;
   logic       res_vld;
   frame_res_t res_type;
   logic [3:0] res_code;

   logic [3:0] low;
   logic [2:0] n_low;
   logic [2:0] sum;
   logic [1:0] low_idx;
   logic [1:0] acc_hits;
   logic [3:0] acc_code;

   sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (row),
      .q     (row_s)
   );

   assign low = ~row_s;

   // Merge the current column into the running frame; count saturates at 2.
   always_comb begin
      n_low   = 3'($countones(low));
      low_idx = 2'd0;
      for (int r = 3; r >= 0; r--) begin
         if (low[r]) low_idx = 2'(r);
      end
      sum      = {1'b0, hit_q} + n_low;
      acc_hits = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      acc_code = first_q;
      if (hit_q == 2'd0 && n_low != 3'd0) acc_code = {low_idx, col_idx};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col       <= 4'b1110;
         col_idx   <= 2'd0;
         hit_q     <= 2'd0;
         first_q   <= 4'd0;
         frm_done  <= 1'b0;
         frm_hits  <= 2'd0;
         frm_code  <= 4'd0;
         res_vld   <= 1'b0;
         res_type  <= NONE;
         res_code  <= 4'd0;
         key_multi <= 1'b0;
      end else begin
         frm_done <= 1'b0;
         res_vld  <= frm_done;
         if (frm_done) begin
            res_type  <= (frm_hits == 2'd0) ? NONE :
                         (frm_hits == 2'd1) ? SINGLE : MULTI;
            res_code  <= frm_code;
            key_multi <= (frm_hits == 2'd2);
         end
         if (tick_scan) begin
            col_idx <= col_idx + 2'd1;
            col     <= ~(4'b0001 << (col_idx + 2'd1));
            if (col_idx == 2'd3) begin
               frm_hits <= acc_hits;
               frm_code <= acc_code;
               frm_done <= 1'b1;
               hit_q    <= 2'd0;
               first_q  <= 4'd0;
            end else begin
               hit_q    <= acc_hits;
               first_q  <= acc_code;
            end
         end
      end
   end

   kp_state_t  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [7:0] rep_q, rep_d;
   logic [3:0] cand_q, cand_d;
   logic [3:0] code_d;
   logic       valid_d;
   logic       got_single;
   logic       got_empty;
   logic       accept;

   // MULTI frames count as empty: only a lone key can press or hold.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rep_d      = rep_q;
      cand_d     = cand_q;
      code_d     = key_code;
      valid_d    = 1'b0;
      accept     = 1'b0;
      got_single = res_vld && (res_type == SINGLE);
      got_empty  = res_vld && (res_type != SINGLE);
      case (state_q)
         IDLE: begin
            if (got_single) begin
               cand_d = res_code;
               if (DEB_N == 4'd1) begin
                  accept = 1'b1;
               end else begin
                  state_d = DEB;
                  cnt_d   = 4'd1;
               end
            end
         end
         DEB: begin
            if (got_single && res_code == cand_q) begin
               if (cnt_q + 4'd1 == DEB_N) accept = 1'b1;
               else                       cnt_d  = cnt_q + 4'd1;
            end else if (res_vld) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         end
         HELD: begin
            if (got_empty) begin
               rep_d = 8'd0;
               if (DEB_N == 4'd1) begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = REL;
                  cnt_d   = 4'd1;
               end
            end else if (got_single && REP_N != 8'd0 && res_code == cand_q) begin
               if (rep_q + 8'd1 == REP_N) begin
                  valid_d = 1'b1;
                  rep_d   = 8'd0;
               end else begin
                  rep_d   = rep_q + 8'd1;
               end
            end
         end
         REL: begin
            if (got_empty) begin
               if (cnt_q + 4'd1 == DEB_N) begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d   = cnt_q + 4'd1;
               end
            end else if (got_single) begin
               state_d = HELD;
            end
         end
         default: state_d = IDLE;
      endcase
      if (accept) begin
         code_d  = cand_d;
         valid_d = 1'b1;
         state_d = HELD;
         cnt_d   = 4'd0;
         rep_d   = 8'd0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= 4'd0;
         rep_q     <= 8'd0;
         cand_q    <= 4'd0;
         key_code  <= 4'd0;
         key_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rep_q     <= rep_d;
         cand_q    <= cand_d;
         key_code  <= code_d;
         key_valid <= valid_d;
      end
   end

   assign key_held = (state_q == HELD) || (state_q == REL);

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Scans a 4x4 matrix keypad, the input-side counterpart to the multiplexed seven-segment output scan. Drives one column low at a time on the shared scan strobe and samples the synchronised rows. Debounces over whole scan frames and emits a single-cycle key event with a 4-bit key position. Its events feed the alarm-edit and password-entry logic that in turn selects cursor position and text modes on the display.

Parameters:
DEBOUNCE_FRAMES, 3, consecutive identical frames required to accept a press or a release (range 1..15)
REPEAT_FRAMES, 0, frames between auto-repeat events while held; 0 disables auto-repeat (range 0..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
tick_scan  in  1  single-cycle scan strobe; pulses at least 4 clk apart
row  in  4  keypad rows, active-low, externally pulled up, asynchronous
col  out  4  column drive, active-low, exactly one bit low
key_valid  out  1  single-cycle pulse: accepted press or auto-repeat
key_code  out  4  key position, {row_idx[1:0], col_idx[1:0]}; valid with key_valid, held until the next event
key_held  out  1  high while the FSM is in HELD or REL
key_multi  out  1  high when the last completed frame saw more than one pressed key

Behaviour:
- Reset (synchronous; takes priority over tick_scan): col=4'b1110, col_idx=0, row synchroniser=4'b1111, key_valid=0, key_code=0, key_held=0, key_multi=0, FSM=IDLE, all counters=0, frame accumulators cleared.
- Row input passes through a 2-flop synchroniser before any use.
- On each tick_scan:
  - Sample the synchronised row for the current col_idx into the frame accumulator.
  - Then advance col_idx mod 4 and update col to ~(1<<col_idx) on the same edge.
  - Rows therefore settle for one full tick period.
- Frame = 4 ticks, columns 0..3. The tick that samples column 3 is the frame-end.
- Frame accumulator counts low row bits over the frame, saturating at 2, and records the {row,col} of the first hit.
  - Frame result is NONE (0 hits), SINGLE(code) (1 hit) or MULTI (2 or more).
  - If one column has several rows low, the lowest row index is recorded as first hit; the count still reaches MULTI.
- At frame-end the result is registered (1 clk). key_multi=1 if MULTI, else 0. The FSM evaluates the result on that cycle. MULTI is treated as NONE by the FSM.
- FSM (evaluated at frame-end only; state holds otherwise):
  - IDLE: SINGLE(c) -> cand=c, cnt=1; go to DEB if DEBOUNCE_FRAMES>1, else accept. Otherwise stay in IDLE.
  - DEB:
    - SINGLE(cand) -> cnt++. On reaching DEBOUNCE_FRAMES, accept.
    - Any other result -> IDLE, cnt=0.
  - Accept: key_code<=cand, key_valid=1 for exactly one clk, go to HELD, rep_cnt=0.
  - HELD:
    - NONE/MULTI -> REL, cnt=1; if DEBOUNCE_FRAMES=1, go directly to IDLE.
    - SINGLE (any code) -> stay; rollover to a different key is ignored.
    - Auto-repeat (REPEAT_FRAMES>0): each SINGLE(cand) frame increments rep_cnt. On reaching REPEAT_FRAMES, pulse key_valid with the same key_code and reset rep_cnt=0.
  - REL:
    - NONE/MULTI -> cnt++. On reaching DEBOUNCE_FRAMES, go to IDLE.
    - SINGLE (any) -> back to HELD, rep_cnt unchanged.
- Latency: key_valid asserts 2 clk after the frame-end tick of the DEBOUNCE_FRAMES-th qualifying frame (1 clk frame-result register + 1 clk FSM output register).
- Counters: cnt 4 bits, rep_cnt 8 bits, both reset on every state entry except REL->HELD. No wrap is reachable because the parameter ranges are bounded.
- key_code never changes except on accept. No key_valid is ever issued from REL or IDLE.

Decomposition:
- Shared package kp_pkg:
  - FSM state enum {IDLE, DEB, HELD, REL}
  - frame-result enum {NONE, SINGLE, MULTI}
  - constant KEY_MAP[16], position -> 5-bit display char code:
    - row 0: 1 2 3 A
    - row 1: 4 5 6 b
    - row 2: 7 8 9 C
    - row 3: E(*) 0 F(#) d
  - This is consumed by the edit logic, not by this block.
- One sub-module, sync2 (4-bit 2-flop synchroniser, reset value 1), reused by the button inputs elsewhere.

Test Plan:
Bench: tick_scan every 4 clk; keypad model drives row[r]=0 iff col[c]==0 and key (r,c) is pressed.
- Clean press, key (1,2) held 5 frames, DEBOUNCE_FRAMES=3 -> exactly one key_valid; key_code=4'h6, asserted 2 clk after the 3rd frame-end; key_held=1 thereafter.
- Bounce: key (0,0) pressed 2 frames, open 1 frame, pressed 3 frames -> one key_valid only, at the end of the final 3 frames; key_code=4'h0.
- Keys (2,1) and (3,3) pressed together for 6 frames -> key_multi=1 from the 1st frame-end, no key_valid, key_held=0.
- Release glitch: after accepting (3,1) (code 4'hD), open 2 frames then press again -> no new key_valid, key_held stays 1. Then open 3 frames -> key_held=0, and a re-press gives a new key_valid after 3 frames.
- REPEAT_FRAMES=8, key (0,3) held 30 frames -> key_valid at frames 3, 11, 19, 27, all with key_code=4'h3.
- reset asserted in DEB with cnt=2, coincident with tick_scan -> next cycle col=4'b1110, key_valid=0, key_code=0; a continued press needs 3 full new frames to be accepted.
